pong_game_ctrl: RTL and testbench

//  Game-sequencing controller for the pong graphics datapath. Decides when the

---
 rtl/pong_game_ctrl.sv | 128 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing controller: play/pause state machine, BCD score,
// remaining-ball count and frame-counted pause timer. All outputs registered.
module pong_game_ctrl #(
  parameter int unsigned N_BALLS      = 3,
  parameter int unsigned TIMER_FRAMES = 120,
  parameter int unsigned TIMER_W      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       graph_still,
  output logic       ball_reload,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic [1:0] state,
  output logic       timer_done
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           d1_q, d1_d, d0_q, d0_d;
  logic [1:0]           balls_q, balls_d;
  logic                 reload_d;
  logic                 still_q, reload_q, tdone_q;

  // Next-state, score, ball count and pause-timer computation
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    d1_d     = d1_q;
    d0_d     = d0_q;
    balls_d  = balls_q;
    reload_d = 1'b0;

    // Free-running countdown; a load below overrides it in the same cycle
    if (refr_tick && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      NEWGAME: begin
        if (btn != 2'b00) begin
          state_d  = PLAY;
          d1_d     = '0;
          d0_d     = '0;
          balls_d  = 2'(N_BALLS);
          reload_d = 1'b1;
        end
      end
      PLAY: begin
        if (hit) begin
          if (d0_q == 4'd9) begin
            d0_d = '0;
            d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
          end else begin
            d0_d = d0_q + 4'd1;
          end
        end
        if (miss) begin
          timer_d = TIMER_W'(TIMER_FRAMES);
          if (balls_q > 2'd1) begin
            balls_d = balls_q - 2'd1;
            state_d = NEWBALL;
          end else begin
            balls_d = '0;
            state_d = OVER;
          end
        end
      end
      NEWBALL: begin
        if ((timer_q == '0) && (btn != 2'b00)) begin
          state_d  = PLAY;
          reload_d = 1'b1;
        end
      end
      OVER: begin
        if (timer_q == '0) begin
          state_d = NEWGAME;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // State and registered outputs; flags derive from next-state so they
  // change on the same edge as the state and timer they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NEWGAME;
      timer_q  <= '0;
      d1_q     <= '0;
      d0_q     <= '0;
      balls_q  <= 2'(N_BALLS);
      still_q  <= 1'b1;
      reload_q <= 1'b0;
      tdone_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      d1_q     <= d1_d;
      d0_q     <= d0_d;
      balls_q  <= balls_d;
      still_q  <= (state_d != PLAY);
      reload_q <= reload_d;
      tdone_q  <= (timer_d == '0);
    end
  end

  assign graph_still = still_q;
  assign ball_reload = reload_q;
  assign score_d1    = d1_q;
  assign score_d0    = d0_q;
  assign balls_left  = balls_q;
  assign state       = state_q;
  assign timer_done  = tdone_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the driver queues expected output
// snapshots tagged with a clock-edge number; the monitor compares them.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       graph_still, ball_reload, timer_done;
  logic [3:0] score_d1, score_d0;
  logic [1:0] balls_left, state;

  localparam logic [1:0] S_NEWGAME = 2'b00;
  localparam logic [1:0] S_PLAY    = 2'b01;
  localparam logic [1:0] S_NEWBALL = 2'b10;
  localparam logic [1:0] S_OVER    = 2'b11;

  pong_game_ctrl #(.N_BALLS(3), .TIMER_FRAMES(120), .TIMER_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .refr_tick  (refr_tick),
    .btn        (btn),
    .hit        (hit),
    .miss       (miss),
    .graph_still(graph_still),
    .ball_reload(ball_reload),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left),
    .state      (state),
    .timer_done (timer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] st;
    logic       still;
    logic       rl;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [1:0] bl;
    logic       td;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event kick;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are stable mid-cycle; also woken for async-reset checks
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or kick);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (state !== e.st || graph_still !== e.still || ball_reload !== e.rl ||
            score_d1 !== e.d1 || score_d0 !== e.d0 || balls_left !== e.bl ||
            timer_done !== e.td) begin
          errors++;
          $display("FAIL %s @%0d: got st=%0d still=%0d rl=%0d score=%0d%0d balls=%0d tdone=%0d, exp st=%0d still=%0d rl=%0d score=%0d%0d balls=%0d tdone=%0d",
                   e.name, e.cyc, state, graph_still, ball_reload, score_d1, score_d0,
                   balls_left, timer_done, e.st, e.still, e.rl, e.d1, e.d0, e.bl, e.td);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string name, input logic [1:0] st, input logic rl,
                            input int score, input int balls, input logic td);
    exp_t e;
    e.name  = name;
    e.cyc   = cyc;
    e.st    = st;
    e.still = (st != S_PLAY);
    e.rl    = rl;
    e.d1    = 4'(score / 10);
    e.d0    = 4'(score % 10);
    e.bl    = 2'(balls);
    e.td    = td;
    q.push_back(e);
  endtask

  // Apply one cycle of inputs; returns 1 ns after the sampling edge
  task automatic step(input logic [1:0] b, input logic h, input logic m, input logic t);
    btn = b; hit = h; miss = m; refr_tick = t;
    @(posedge clk); #1;
    btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", S_NEWGAME, 1'b0, 0, 3, 1'b1);
    reset = 1'b0;

    // Start game
    step(2'b01, 0, 0, 0); expect_out("start_play", S_PLAY, 1'b1, 0, 3, 1'b1);
    step(2'b00, 0, 0, 0); expect_out("reload_1cyc", S_PLAY, 1'b0, 0, 3, 1'b1);

    // Score walk 00..99 -> 00
    for (int i = 1; i <= 100; i++) begin
      step(2'b00, 1, 0, 0);
      expect_out("hit_walk", S_PLAY, 1'b0, i % 100, 3, 1'b1);
    end

    // First miss, btn held through pause
    step(2'b00, 0, 1, 0); expect_out("miss1", S_NEWBALL, 1'b0, 0, 2, 1'b0);
    for (int k = 1; k <= 120; k++) begin
      step(2'b01, 0, 0, 1);
      expect_out("pause1_hold", S_NEWBALL, 1'b0, 0, 2, (k == 120));
    end
    step(2'b01, 0, 0, 0); expect_out("resume1", S_PLAY, 1'b1, 0, 2, 1'b1);
    step(2'b00, 0, 0, 0); expect_out("resume1_rl0", S_PLAY, 1'b0, 0, 2, 1'b1);

    // Second miss, no button: must wait for btn after timer expiry
    step(2'b00, 0, 1, 0); expect_out("miss2", S_NEWBALL, 1'b0, 0, 1, 1'b0);
    for (int k = 1; k <= 120; k++) begin
      step(2'b00, 0, 0, 1);
      expect_out("pause2", S_NEWBALL, 1'b0, 0, 1, (k == 120));
    end
    step(2'b00, 0, 0, 0); expect_out("pause2_nobtn", S_NEWBALL, 1'b0, 0, 1, 1'b1);
    step(2'b10, 0, 0, 0); expect_out("resume2", S_PLAY, 1'b1, 0, 1, 1'b1);

    // Reach 41, then hit+miss with coincident refr_tick
    for (int i = 1; i <= 41; i++) begin
      step(2'b00, 1, 0, 0);
      expect_out("hit_to41", S_PLAY, 1'b0, i, 1, 1'b1);
    end
    step(2'b00, 1, 1, 1); expect_out("hit_miss_over", S_OVER, 1'b0, 42, 0, 1'b0);

    // Game over pause: btn and hit ignored; timer loaded to 120 not 119
    for (int k = 1; k <= 120; k++) begin
      step(2'b11, 1, 0, 1);
      expect_out("over_pause", S_OVER, 1'b0, 42, 0, (k == 120));
    end
    step(2'b00, 0, 0, 0); expect_out("over_to_newgame", S_NEWGAME, 1'b0, 42, 0, 1'b1);
    step(2'b00, 1, 1, 0); expect_out("newgame_hold", S_NEWGAME, 1'b0, 42, 0, 1'b1);
    step(2'b01, 0, 0, 0); expect_out("new_game", S_PLAY, 1'b1, 0, 3, 1'b1);

    // Async reset in the middle of a pause
    for (int i = 1; i <= 3; i++) begin
      step(2'b00, 1, 0, 0);
      expect_out("hit_pre_reset", S_PLAY, 1'b0, i, 3, 1'b1);
    end
    step(2'b00, 0, 1, 0); expect_out("miss_pre_reset", S_NEWBALL, 1'b0, 3, 2, 1'b0);
    for (int k = 1; k <= 63; k++) begin
      step(2'b00, 0, 0, 1);
      expect_out("pause_pre_reset", S_NEWBALL, 1'b0, 3, 2, 1'b0);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    expect_out("async_reset", S_NEWGAME, 1'b0, 0, 3, 1'b1);
    -> kick;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    step(2'b01, 0, 0, 0); expect_out("post_reset_play", S_PLAY, 1'b1, 0, 3, 1'b1);

    // Drain scoreboard with a bounded wait
    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, exp 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
